// File: rtl/csr_file.sv
// Machine-mode CSR register file with two independent read/write ports (ex, clint).
module csr_file #(
   parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
   parameter logic [31:0] HART_ID     = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_retire_i,
   input  logic        ex_we_i,
   input  logic [31:0] ex_waddr_i,
   input  logic [31:0] ex_wdata_i,
   input  logic [31:0] ex_raddr_i,
   output logic [31:0] ex_rdata_o,
   input  logic        clint_we_i,
   input  logic [31:0] clint_waddr_i,
   input  logic [31:0] clint_wdata_i,
   input  logic [31:0] clint_raddr_i,
   output logic [31:0] clint_rdata_o,
   output logic [31:0] csr_mtvec_o,
   output logic [31:0] csr_mepc_o,
   output logic [31:0] csr_mstatus_o,
   output logic        global_int_en_o
);

   localparam int unsigned XLEN = 32;
   localparam int unsigned AW   = 12;
   localparam int unsigned NREG = 10;
   localparam int unsigned IW   = 4;

   localparam logic [AW-1:0] A_MSTATUS   = 12'h300;
   localparam logic [AW-1:0] A_MIE       = 12'h304;
   localparam logic [AW-1:0] A_MTVEC     = 12'h305;
   localparam logic [AW-1:0] A_MSCRATCH  = 12'h340;
   localparam logic [AW-1:0] A_MEPC      = 12'h341;
   localparam logic [AW-1:0] A_MCAUSE    = 12'h342;
   localparam logic [AW-1:0] A_MCYCLE    = 12'hB00;
   localparam logic [AW-1:0] A_MCYCLEH   = 12'hB80;
   localparam logic [AW-1:0] A_MINSTRET  = 12'hB02;
   localparam logic [AW-1:0] A_MINSTRETH = 12'hB82;
   localparam logic [AW-1:0] A_CYCLE     = 12'hC00;
   localparam logic [AW-1:0] A_CYCLEH    = 12'hC80;
   localparam logic [AW-1:0] A_MHARTID   = 12'hF14;

   localparam int unsigned I_MSTATUS   = 0;
   localparam int unsigned I_MIE       = 1;
   localparam int unsigned I_MTVEC     = 2;
   localparam int unsigned I_MSCRATCH  = 3;
   localparam int unsigned I_MEPC      = 4;
   localparam int unsigned I_MCAUSE    = 5;
   localparam int unsigned I_MCYCLE    = 6;
   localparam int unsigned I_MCYCLEH   = 7;
   localparam int unsigned I_MINSTRET  = 8;
   localparam int unsigned I_MINSTRETH = 9;

   localparam logic [XLEN-1:0] MSTATUS_RESET = 32'h0000_1800;
   localparam logic [XLEN-1:0] MSTATUS_WMASK = 32'h0000_0088;

   logic [XLEN-1:0] r_mstatus, r_mie, r_mtvec, r_mscratch, r_mepc, r_mcause;
   logic [XLEN-1:0] r_mcycle_l, r_mcycle_h, r_minstret_l, r_minstret_h;

   logic [AW-1:0]   w_ex_a, w_cl_a;
   logic            w_ex_wr, w_cl_wr;
   logic [XLEN-1:0] w_ex_d, w_cl_d;
   logic [NREG-1:0] w_we_ex, w_we_cl, w_we;
   logic [63:0]     w_cyc_inc, w_ins_inc;
   logic            w_unused_addr_bits;

   // Writable CSR decode.
   function automatic logic is_wr(input logic [AW-1:0] a);
      case (a)
         A_MSTATUS, A_MIE, A_MTVEC, A_MSCRATCH, A_MEPC, A_MCAUSE,
         A_MCYCLE, A_MCYCLEH, A_MINSTRET, A_MINSTRETH: is_wr = 1'b1;
         default:                                      is_wr = 1'b0;
      endcase
   endfunction

   // Index of a writable CSR in the enable vectors.
   function automatic logic [IW-1:0] csr_idx(input logic [AW-1:0] a);
      case (a)
         A_MIE:       csr_idx = IW'(I_MIE);
         A_MTVEC:     csr_idx = IW'(I_MTVEC);
         A_MSCRATCH:  csr_idx = IW'(I_MSCRATCH);
         A_MEPC:      csr_idx = IW'(I_MEPC);
         A_MCAUSE:    csr_idx = IW'(I_MCAUSE);
         A_MCYCLE:    csr_idx = IW'(I_MCYCLE);
         A_MCYCLEH:   csr_idx = IW'(I_MCYCLEH);
         A_MINSTRET:  csr_idx = IW'(I_MINSTRET);
         A_MINSTRETH: csr_idx = IW'(I_MINSTRETH);
         default:     csr_idx = IW'(I_MSTATUS);
      endcase
   endfunction

   // Field masking applied to write data before it is stored or bypassed.
   function automatic logic [XLEN-1:0] wmask(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
      case (a)
         A_MSTATUS: wmask = (d & MSTATUS_WMASK) | MSTATUS_RESET;
         A_MTVEC:   wmask = {d[XLEN-1:2], 2'b00};
         A_MEPC:    wmask = {d[XLEN-1:1], 1'b0};
         default:   wmask = d;
      endcase
   endfunction

   // Stored (pre-increment) value at a CSR address.
   function automatic logic [XLEN-1:0] rd_stored(input logic [AW-1:0] a);
      case (a)
         A_MSTATUS:            rd_stored = r_mstatus;
         A_MIE:                rd_stored = r_mie;
         A_MTVEC:              rd_stored = r_mtvec;
         A_MSCRATCH:           rd_stored = r_mscratch;
         A_MEPC:               rd_stored = r_mepc;
         A_MCAUSE:             rd_stored = r_mcause;
         A_MCYCLE, A_CYCLE:    rd_stored = r_mcycle_l;
         A_MCYCLEH, A_CYCLEH:  rd_stored = r_mcycle_h;
         A_MINSTRET:           rd_stored = r_minstret_l;
         A_MINSTRETH:          rd_stored = r_minstret_h;
         A_MHARTID:            rd_stored = HART_ID;
         default:              rd_stored = '0;
      endcase
   endfunction

   // Read with bypass of the winning same-cycle write.
   function automatic logic [XLEN-1:0] rd_port(input logic [AW-1:0] a);
      if (w_ex_wr && (w_ex_a == a))      rd_port = w_ex_d;
      else if (w_cl_wr && (w_cl_a == a)) rd_port = w_cl_d;
      else                               rd_port = rd_stored(a);
   endfunction

   assign w_ex_a  = ex_waddr_i[AW-1:0];
   assign w_cl_a  = clint_waddr_i[AW-1:0];
   assign w_ex_wr = ex_we_i & is_wr(w_ex_a);
   assign w_cl_wr = clint_we_i & is_wr(w_cl_a) & ~(w_ex_wr & (w_ex_a == w_cl_a));
   assign w_ex_d  = wmask(w_ex_a, ex_wdata_i);
   assign w_cl_d  = wmask(w_cl_a, clint_wdata_i);
   assign w_unused_addr_bits = ^{ex_waddr_i[31:AW], clint_waddr_i[31:AW],
                                 ex_raddr_i[31:AW], clint_raddr_i[31:AW]};

   // One-hot write enables per port; ex wins a same-CSR collision via w_cl_wr.
   always_comb begin
      w_we_ex = '0;
      w_we_cl = '0;
      if (w_ex_wr) w_we_ex = NREG'(1) << csr_idx(w_ex_a);
      if (w_cl_wr) w_we_cl = NREG'(1) << csr_idx(w_cl_a);
      w_we = w_we_ex | w_we_cl;
   end

   assign w_cyc_inc = {r_mcycle_h, r_mcycle_l} + 64'd1;
   assign w_ins_inc = {r_minstret_h, r_minstret_l} + 64'(inst_retire_i);

   // Combinational read ports.
   always_comb begin
      ex_rdata_o    = rd_port(ex_raddr_i[AW-1:0]);
      clint_rdata_o = rd_port(clint_raddr_i[AW-1:0]);
   end

   // CSR storage and counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mstatus    <= MSTATUS_RESET;
         r_mie        <= '0;
         r_mtvec      <= {MTVEC_RESET[XLEN-1:2], 2'b00};
         r_mscratch   <= '0;
         r_mepc       <= '0;
         r_mcause     <= '0;
         r_mcycle_l   <= '0;
         r_mcycle_h   <= '0;
         r_minstret_l <= '0;
         r_minstret_h <= '0;
      end else begin
         if (w_we[I_MSTATUS])  r_mstatus  <= w_we_ex[I_MSTATUS]  ? w_ex_d : w_cl_d;
         if (w_we[I_MIE])      r_mie      <= w_we_ex[I_MIE]      ? w_ex_d : w_cl_d;
         if (w_we[I_MTVEC])    r_mtvec    <= w_we_ex[I_MTVEC]    ? w_ex_d : w_cl_d;
         if (w_we[I_MSCRATCH]) r_mscratch <= w_we_ex[I_MSCRATCH] ? w_ex_d : w_cl_d;
         if (w_we[I_MEPC])     r_mepc     <= w_we_ex[I_MEPC]     ? w_ex_d : w_cl_d;
         if (w_we[I_MCAUSE])   r_mcause   <= w_we_ex[I_MCAUSE]   ? w_ex_d : w_cl_d;

         // Low-half write suppresses the carry; high-half write overrides it.
         if (w_we[I_MCYCLE]) r_mcycle_l <= w_we_ex[I_MCYCLE] ? w_ex_d : w_cl_d;
         else                r_mcycle_l <= w_cyc_inc[31:0];
         if (w_we[I_MCYCLEH])     r_mcycle_h <= w_we_ex[I_MCYCLEH] ? w_ex_d : w_cl_d;
         else if (!w_we[I_MCYCLE]) r_mcycle_h <= w_cyc_inc[63:32];

         if (w_we[I_MINSTRET]) r_minstret_l <= w_we_ex[I_MINSTRET] ? w_ex_d : w_cl_d;
         else                  r_minstret_l <= w_ins_inc[31:0];
         if (w_we[I_MINSTRETH])      r_minstret_h <= w_we_ex[I_MINSTRETH] ? w_ex_d : w_cl_d;
         else if (!w_we[I_MINSTRET]) r_minstret_h <= w_ins_inc[63:32];
      end
   end

   assign csr_mtvec_o     = r_mtvec;
   assign csr_mepc_o      = r_mepc;
   assign csr_mstatus_o   = r_mstatus;
   assign global_int_en_o = r_mstatus[3];

endmodule
